// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving the registered 4x1 mux select
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic             valid,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] win;
  logic       found;
  logic       keep;

  // Rotating search starts one past the current owner (or the last owner when idle);
  // the base itself is tried last, which lets a solo owner be re-granted on timeout.
  always_comb begin
    base  = (state_q == GRANT) ? sel_q : last_q;
    found = 1'b0;
    win   = base;
    idx   = base;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign keep = (state_q == GRANT) && req[sel_q] && (cnt_q < HOLD_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (keep) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (found) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      last_d  = win;
      cnt_d   = '0;
    end else begin
      // Select keeps its last value while idle.
      state_d = IDLE;
      gnt_d   = 4'b0000;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign s1       = sel_q[1];
  assign s0       = sel_q[0];
  assign valid    = (state_q == GRANT);
  assign hold_cnt = cnt_q;

endmodule
